vx_stream_pkt_arb: RTL and testbench

Packet-aware N-to-1 stream arbiter. It sits directly downstream of the request sources that feed a round-robin arbiter. It selects one valid input stream in round-robin order and holds that selection for a whole multi-beat packet. The chosen beats go through a two-entry registered skid buffer, so `ready_in` never depends combinationally on `ready_out`. Typical use is merging per-warp or per-bank packet streams onto one shared channel.

---
 rtl/vx_stream_pkt_arb.sv | 166 ++++++++++++++++
 tb/tb_vx_stream_pkt_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_stream_pkt_arb.sv
// Packet-aware round-robin N:1 stream arbiter feeding a two-entry registered skid buffer.
// Latency: 1 cycle from input accept to valid_out; backpressure: ready_in is registered-only (at most one beat lands in the skid).
module vx_stream_pkt_arb #(
    parameter int NUM_INPUTS     = 4,
    parameter int DATAW          = 32,
    parameter int LOG_NUM_INPUTS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    input  logic [NUM_INPUTS-1:0]       last_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic                        last_out,
    output logic [LOG_NUM_INPUTS-1:0]   sel_out,
    input  logic                        ready_out,
    output logic                        locked
);

    typedef struct packed {
        logic [DATAW-1:0]          dat;
        logic                      last;
        logic [LOG_NUM_INPUTS-1:0] idx;
    } beat_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    localparam logic [LOG_NUM_INPUTS:0]   NUM_W    = (LOG_NUM_INPUTS+1)'(NUM_INPUTS);
    localparam logic [LOG_NUM_INPUTS-1:0] LAST_IDX = LOG_NUM_INPUTS'(NUM_INPUTS - 1);

    buf_state_t                state, state_nxt;
    beat_t                     out_beat, skid_beat, beat_in;
    logic [LOG_NUM_INPUTS-1:0] ptr, lock_idx;
    logic                      locked_q;

    logic                      scan_vld;
    logic [LOG_NUM_INPUTS-1:0] scan_idx;
    logic [LOG_NUM_INPUTS:0]   cand;
    logic [LOG_NUM_INPUTS-1:0] grant_idx;
    logic                      grant_vld;
    logic                      grant_en;
    logic                      buf_ready;
    logic                      in_fire;
    logic [LOG_NUM_INPUTS-1:0] ptr_nxt;
    logic                      load_out, load_skid, out_from_skid;

    // First valid input scanning from ptr upward, wrapping at NUM_INPUTS.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = ptr;
        cand     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cand = {1'b0, ptr} + (LOG_NUM_INPUTS+1)'(i);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!scan_vld && valid_in[cand[LOG_NUM_INPUTS-1:0]]) begin
                scan_vld = 1'b1;
                scan_idx = cand[LOG_NUM_INPUTS-1:0];
            end
        end
    end

    assign grant_idx = locked_q ? lock_idx : scan_idx;
    // A locked grant stays asserted through bubbles so no other input can slip in.
    assign grant_en  = locked_q || scan_vld;
    assign buf_ready = reset && (state != BUF_FULL);

    always_comb begin
        grant_vld    = 1'b0;
        beat_in.dat  = '0;
        beat_in.last = 1'b0;
        beat_in.idx  = grant_idx;
        ready_in     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == LOG_NUM_INPUTS'(i)) begin
                grant_vld    = valid_in[i];
                beat_in.dat  = data_in[i*DATAW +: DATAW];
                beat_in.last = last_in[i];
                ready_in[i]  = buf_ready && grant_en;
            end
        end
    end

    assign in_fire = grant_vld && grant_en && buf_ready;
    assign ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (in_fire) begin
                    load_out  = 1'b1;
                    state_nxt = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (in_fire && ready_out) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = BUF_FULL;
                end else if (ready_out) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (ready_out) begin
                    out_from_skid = 1'b1;
                    state_nxt     = BUF_ONE;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BUF_EMPTY;
            out_beat  <= '0;
            skid_beat <= '0;
        end else begin
            state <= state_nxt;
            if (out_from_skid) begin
                out_beat <= skid_beat;
            end else if (load_out) begin
                out_beat <= beat_in;
            end
            if (load_skid) begin
                skid_beat <= beat_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock_idx <= '0;
            locked_q <= 1'b0;
        end else if (in_fire) begin
            if (beat_in.last) begin
                locked_q <= 1'b0;
                ptr      <= ptr_nxt;
            end else begin
                locked_q <= 1'b1;
                lock_idx <= grant_idx;
            end
        end
    end

    assign valid_out = (state != BUF_EMPTY);
    assign data_out  = out_beat.dat;
    assign last_out  = out_beat.last;
    assign sel_out   = out_beat.idx;
    assign locked    = locked_q;

endmodule

// File: tb/tb_vx_stream_pkt_arb.sv
// Directed table-driven bench for vx_stream_pkt_arb: 4-input and 1-input instances.
module tb_vx_stream_pkt_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   a_valid_in, a_last_in, a_ready_in;
    logic [127:0] a_data_in;
    logic         a_valid_out, a_last_out, a_ready_out, a_locked;
    logic [31:0]  a_data_out;
    logic [1:0]   a_sel_out;

    logic [0:0]   b_valid_in, b_last_in, b_ready_in, b_sel_out;
    logic [31:0]  b_data_in, b_data_out;
    logic         b_valid_out, b_last_out, b_ready_out, b_locked;

    vx_stream_pkt_arb #(.NUM_INPUTS(4), .DATAW(32)) dut4 (
        .clk(clk), .reset(reset),
        .valid_in(a_valid_in), .data_in(a_data_in), .last_in(a_last_in),
        .ready_in(a_ready_in), .valid_out(a_valid_out), .data_out(a_data_out),
        .last_out(a_last_out), .sel_out(a_sel_out), .ready_out(a_ready_out),
        .locked(a_locked)
    );

    vx_stream_pkt_arb #(.NUM_INPUTS(1), .DATAW(32)) dut1 (
        .clk(clk), .reset(reset),
        .valid_in(b_valid_in), .data_in(b_data_in), .last_in(b_last_in),
        .ready_in(b_ready_in), .valid_out(b_valid_out), .data_out(b_data_out),
        .last_out(b_last_out), .sel_out(b_sel_out), .ready_out(b_ready_out),
        .locked(b_locked)
    );

    typedef struct packed {
        logic [3:0]  vin;
        logic [3:0]  lin;
        logic [31:0] d;
        logic        ro;
        logic        vo;
        logic [1:0]  sel;
        logic        last;
        logic [31:0] dat;
        logic [3:0]  ri;
        logic        lk;
    } vec_t;

    vec_t tab4[22];
    vec_t tab1[6];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [3:0] vin, input logic [3:0] lin, input logic [31:0] d,
                                input logic ro, input logic vo, input logic [1:0] sel, input logic last,
                                input logic [31:0] dat, input logic [3:0] ri, input logic lk);
        vec_t v;
        v.vin = vin; v.lin = lin; v.d = d; v.ro = ro; v.vo = vo;
        v.sel = sel; v.last = last; v.dat = dat; v.ri = ri; v.lk = lk;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive4(input vec_t v);
        a_valid_in  = v.vin;
        a_last_in   = v.lin;
        a_ready_out = v.ro;
        for (int i = 0; i < 4; i++) a_data_in[i*32 +: 32] = v.d + 32'(i);
    endtask

    task automatic check4(input int k, input vec_t v);
        chk("a_valid_out", k, 32'(a_valid_out), 32'(v.vo));
        chk("a_ready_in",  k, 32'(a_ready_in),  32'(v.ri));
        chk("a_locked",    k, 32'(a_locked),    32'(v.lk));
        if (v.vo) begin
            chk("a_sel_out",  k, 32'(a_sel_out),  32'(v.sel));
            chk("a_last_out", k, 32'(a_last_out), 32'(v.last));
            chk("a_data_out", k, a_data_out,      v.dat);
        end
    endtask

    task automatic check1(input int k, input vec_t v);
        chk("b_valid_out", k, 32'(b_valid_out), 32'(v.vo));
        chk("b_ready_in",  k, 32'(b_ready_in),  32'(v.ri[0]));
        chk("b_locked",    k, 32'(b_locked),    32'(v.lk));
        if (v.vo) begin
            chk("b_sel_out",  k, 32'(b_sel_out),  32'(v.sel));
            chk("b_last_out", k, 32'(b_last_out), 32'(v.last));
            chk("b_data_out", k, b_data_out,      v.dat);
        end
    endtask

    initial begin
        //                vin     lin     d         ro vo sel last dat        ri      lk
        // single-beat round robin, all inputs valid
        tab4[0]  = mk(4'hF,   4'hF,   32'h0100, 1, 0, 0, 0, 32'h0,    4'b0001, 0);
        tab4[1]  = mk(4'hF,   4'hF,   32'h0200, 1, 1, 0, 1, 32'h0100, 4'b0010, 0);
        tab4[2]  = mk(4'hF,   4'hF,   32'h0300, 1, 1, 1, 1, 32'h0201, 4'b0100, 0);
        tab4[3]  = mk(4'hF,   4'hF,   32'h0400, 1, 1, 2, 1, 32'h0302, 4'b1000, 0);
        tab4[4]  = mk(4'hF,   4'hF,   32'h0500, 1, 1, 3, 1, 32'h0403, 4'b0001, 0);
        tab4[5]  = mk(4'hF,   4'hF,   32'h0600, 1, 1, 0, 1, 32'h0500, 4'b0010, 0);
        // 3-beat packet from input 2 with a bubble; input 0 contends
        tab4[6]  = mk(4'b0101, 4'b0001, 32'h0700, 1, 1, 1, 1, 32'h0601, 4'b0100, 0);
        tab4[7]  = mk(4'b0001, 4'b0001, 32'h0800, 1, 1, 2, 0, 32'h0702, 4'b0100, 1);
        tab4[8]  = mk(4'b0101, 4'b0001, 32'h0900, 1, 0, 0, 0, 32'h0,    4'b0100, 1);
        tab4[9]  = mk(4'b0101, 4'b0101, 32'h0A00, 1, 1, 2, 0, 32'h0902, 4'b0100, 1);
        tab4[10] = mk(4'b0001, 4'b0001, 32'h0B00, 1, 1, 2, 1, 32'h0A02, 4'b0001, 0);
        tab4[11] = mk(4'b0000, 4'b0000, 32'h0C00, 1, 1, 0, 1, 32'h0B00, 4'b0000, 0);
        tab4[12] = mk(4'b0000, 4'b0000, 32'h0D00, 1, 0, 0, 0, 32'h0,    4'b0000, 0);
        // backpressure: A,B,C,D packet on input 1, ready_out low 3 cycles
        tab4[13] = mk(4'b0010, 4'b0000, 32'h0E00, 1, 0, 0, 0, 32'h0,    4'b0010, 0);
        tab4[14] = mk(4'b0010, 4'b0000, 32'h0F00, 0, 1, 1, 0, 32'h0E01, 4'b0010, 1);
        tab4[15] = mk(4'b0010, 4'b0000, 32'h1000, 0, 1, 1, 0, 32'h0E01, 4'b0000, 1);
        tab4[16] = mk(4'b0010, 4'b0000, 32'h1000, 0, 1, 1, 0, 32'h0E01, 4'b0000, 1);
        tab4[17] = mk(4'b0010, 4'b0000, 32'h1000, 1, 1, 1, 0, 32'h0E01, 4'b0000, 1);
        tab4[18] = mk(4'b0010, 4'b0000, 32'h1000, 1, 1, 1, 0, 32'h0F01, 4'b0010, 1);
        tab4[19] = mk(4'b0010, 4'b0010, 32'h1100, 1, 1, 1, 0, 32'h1001, 4'b0010, 1);
        tab4[20] = mk(4'b0000, 4'b0000, 32'h1200, 1, 1, 1, 1, 32'h1101, 4'b0000, 0);
        tab4[21] = mk(4'b0000, 4'b0000, 32'h1300, 1, 0, 0, 0, 32'h0,    4'b0000, 0);

        // single-input: 2-beat packet then a stall
        tab1[0]  = mk(4'b1, 4'b0, 32'h50, 1, 0, 0, 0, 32'h0,  4'b1, 0);
        tab1[1]  = mk(4'b1, 4'b1, 32'h60, 0, 1, 0, 0, 32'h50, 4'b1, 1);
        tab1[2]  = mk(4'b0, 4'b0, 32'h60, 0, 1, 0, 0, 32'h50, 4'b0, 0);
        tab1[3]  = mk(4'b0, 4'b0, 32'h60, 1, 1, 0, 0, 32'h50, 4'b0, 0);
        tab1[4]  = mk(4'b0, 4'b0, 32'h60, 1, 1, 0, 1, 32'h60, 4'b0, 0);
        tab1[5]  = mk(4'b0, 4'b0, 32'h60, 1, 0, 0, 0, 32'h0,  4'b0, 0);

        a_valid_in = '0; a_last_in = '0; a_data_in = '0; a_ready_out = 1'b1;
        b_valid_in = '0; b_last_in = '0; b_data_in = '0; b_ready_out = 1'b1;

        // reset state, with requests present to show ready_in is held low
        #1 reset = 1'b0;
        a_valid_in = 4'hF; a_last_in = 4'hF; b_valid_in = 1'b1;
        #2;
        chk("rst_valid_out", 0, 32'(a_valid_out), 32'h0);
        chk("rst_data_out",  0, a_data_out,       32'h0);
        chk("rst_last_out",  0, 32'(a_last_out),  32'h0);
        chk("rst_sel_out",   0, 32'(a_sel_out),   32'h0);
        chk("rst_locked",    0, 32'(a_locked),    32'h0);
        chk("rst_ready_in",  0, 32'(a_ready_in),  32'h0);
        chk("rst_b_ready_in", 0, 32'(b_ready_in), 32'h0);
        chk("rst_b_valid_out", 0, 32'(b_valid_out), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready_in", 0, 32'(a_ready_in), 32'h0);
        reset = 1'b1;
        a_valid_in = '0; a_last_in = '0; b_valid_in = '0;

        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            drive4(tab4[k]);
            @(negedge clk);
            check4(k, tab4[k]);
        end

        // reset in the middle of a 3-beat packet from input 2 (ptr is 2 here)
        @(posedge clk); #1;
        a_valid_in = 4'b0100; a_last_in = 4'b0000; a_ready_out = 1'b1;
        for (int i = 0; i < 4; i++) a_data_in[i*32 +: 32] = 32'h3000 + 32'(i);
        @(negedge clk);
        chk("mid_ready_in", 0, 32'(a_ready_in), 32'b0100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_valid_out", 0, 32'(a_valid_out), 32'h1);
        chk("mid_locked",    0, 32'(a_locked),    32'h1);
        chk("mid_data_out",  0, a_data_out,       32'h3002);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid_out", 0, 32'(a_valid_out), 32'h0);
        chk("mid_rst_locked",    0, 32'(a_locked),    32'h0);
        chk("mid_rst_ready_in",  0, 32'(a_ready_in),  32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        a_valid_in = 4'b0101; a_last_in = 4'b0101;
        for (int i = 0; i < 4; i++) a_data_in[i*32 +: 32] = 32'h2000 + 32'(i);
        @(negedge clk);
        chk("post_rst_ready_in", 0, 32'(a_ready_in), 32'b0001);
        @(posedge clk); #1;
        a_valid_in = '0;
        @(negedge clk);
        chk("post_rst_valid_out", 0, 32'(a_valid_out), 32'h1);
        chk("post_rst_sel_out",   0, 32'(a_sel_out),   32'h0);
        chk("post_rst_data_out",  0, a_data_out,       32'h2000);

        // single beat from input 3, idle, then 0 and 3 together: ptr wrapped to 0
        @(posedge clk); #1;
        a_valid_in = 4'b1000; a_last_in = 4'b1000;
        for (int i = 0; i < 4; i++) a_data_in[i*32 +: 32] = 32'h4000 + 32'(i);
        @(negedge clk);
        chk("idle_ready_in3", 0, 32'(a_ready_in), 32'b1000);
        @(posedge clk); #1;
        a_valid_in = '0;
        @(negedge clk);
        chk("idle_sel_out3",  0, 32'(a_sel_out), 32'h3);
        chk("idle_data_out3", 0, a_data_out,     32'h4003);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_locked", c, 32'(a_locked), 32'h0);
        end
        @(posedge clk); #1;
        a_valid_in = 4'b1001; a_last_in = 4'b1001;
        for (int i = 0; i < 4; i++) a_data_in[i*32 +: 32] = 32'h5000 + 32'(i);
        @(negedge clk);
        chk("wrap_ready_in", 0, 32'(a_ready_in), 32'b0001);
        @(posedge clk); #1;
        a_valid_in = '0;
        @(negedge clk);
        chk("wrap_valid_out", 0, 32'(a_valid_out), 32'h1);
        chk("wrap_sel_out",   0, 32'(a_sel_out),   32'h0);
        chk("wrap_data_out",  0, a_data_out,       32'h5000);

        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            b_valid_in  = tab1[k].vin[0:0];
            b_last_in   = tab1[k].lin[0:0];
            b_data_in   = tab1[k].d;
            b_ready_out = tab1[k].ro;
            @(negedge clk);
            check1(k, tab1[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
